imem_nibble_loader: RTL and testbench

//  Upstream boot stage for the tinysoc instruction memory. Accepts 4-bit nibbles over a valid/ready

---
 rtl/loader_pkg.sv | 21 ++
 rtl/nibble_packer.sv | 45 ++++
 rtl/imem_nibble_loader.sv | 149 ++++++++++++++
 tb/tb_imem_nibble_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory nibble loader.
// The optional checksum phase is controlled by the LOADER_CHECKSUM_EN macro.
package loader_pkg;

  // Loader phases. CHECK and FAIL are reachable only with LOADER_CHECKSUM_EN.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  localparam int unsigned NIBBLE_WIDTH     = 4;
  localparam int unsigned NIBBLES_PER_WORD = 16 / NIBBLE_WIDTH;

  // Width of a counter that must count 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_packer.sv
// Shift-in packer: collects nibbles LSB-first and flags the accept that
// completes a word. The completed word is presented combinationally so the
// parent can register it together with the write strobe.
module nibble_packer
  import loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  accept_i,
  input  logic [3:0]            nib_i,
  output logic                  word_valid_o,
  output logic [WORD_WIDTH-1:0] word_o
);

  localparam int unsigned NPW = WORD_WIDTH / NIBBLE_WIDTH;
  localparam int unsigned CW  = cnt_width(NPW);

  logic [CW-1:0]         cnt_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic                  last_nib;

  assign last_nib     = (cnt_q == CW'(NPW - 1));
  assign word_valid_o = accept_i & last_nib;
  // New nibbles enter at the top and drift down, so after NPW accepts the
  // first nibble sits in bits [3:0].
  assign word_o       = {nib_i, shift_q[WORD_WIDTH-1:NIBBLE_WIDTH]};

  // Nibble counter and shift register; clear discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (accept_i) begin
      shift_q <= word_o;
      cnt_q   <= last_nib ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/imem_nibble_loader.sv
// Boot loader: packs 4-bit nibbles into instruction words, writes them to
// imem from address 0 to DEPTH-1, then raises done to enable the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing XOR-checksum nibble.
module imem_nibble_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned WORD_WIDTH = NIBBLE_WIDTH * NIBBLES_PER_WORD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  nib_valid,
  input  logic [3:0]            nib_data,
  output logic                  nib_ready,
  input  logic                  reload,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [WORD_WIDTH-1:0] wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ready_q;

  logic                  accept;
  logic                  data_accept;
  logic                  restart;
  logic                  word_valid;
  logic [WORD_WIDTH-1:0] word;

  assign accept      = nib_valid & ready_q;
  assign data_accept = accept & (state_q == ST_LOAD);
  assign restart     = reload & ((state_q == ST_DONE) | (state_q == ST_FAIL));

  nibble_packer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (restart),
    .accept_i     (data_accept),
    .nib_i        (nib_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic       err_q;
  logic [3:0] csum_q;

  // Running XOR over every data nibble; cleared on a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (restart) begin
      csum_q <= '0;
    end else if (data_accept) begin
      csum_q <= csum_q ^ nib_data;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Loader FSM with address counter and registered imem/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      err_q     <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (word_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= word;
            addr_q    <= addr_q + 1'b1;
            if (addr_q == '1) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= ST_CHECK;
`else
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            if (nib_data == csum_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FAIL;
              err_q   <= 1'b1;
            end
          end
        end
`endif
        ST_DONE, ST_FAIL: begin
          if (reload) begin
            state_q <= ST_LOAD;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign nib_ready = ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_imem_nibble_loader.sv
// Self-checking bench for imem_nibble_loader (LOADER_CHECKSUM_EN aware).
module tb_imem_nibble_loader;

  localparam int AW    = 3;
  localparam int WW    = 16;
  localparam int DEPTH = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          nib_valid;
  logic [3:0]    nib_data;
  logic          nib_ready;
  logic          reload;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;

  imem_nibble_loader #(
    .ADDR_WIDTH (AW),
    .WORD_WIDTH (WW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nib_valid (nib_valid),
    .nib_data  (nib_data),
    .nib_ready (nib_ready),
    .reload    (reload),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=loading 1=checking 2=done 3=failed.
  int            m_phase;
  logic [3:0]    m_nibs[$];
  int            m_words;
  logic [3:0]    m_xor;
  logic          m_wr_en;
  logic [AW-1:0] m_wr_addr;
  logic [WW-1:0] m_wr_data;

  task automatic model_reset();
    m_phase   = 0;
    m_nibs.delete();
    m_words   = 0;
    m_xor     = '0;
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
  endtask

  task automatic model_step();
    m_wr_en = 1'b0;
    if (m_phase == 0) begin
      if (nib_valid) begin
        m_nibs.push_back(nib_data);
        m_xor = m_xor ^ nib_data;
        if (m_nibs.size() == 4) begin
          m_wr_data = '0;
          for (int k = 0; k < 4; k++) m_wr_data = m_wr_data | (WW'(m_nibs[k]) << (4 * k));
          m_wr_addr = AW'(m_words);
          m_wr_en   = 1'b1;
          m_nibs.delete();
          m_words++;
          if (m_words == DEPTH) begin
            m_words = 0;
            m_phase = CS ? 1 : 2;
          end
        end
      end
    end else if (m_phase == 1) begin
      if (nib_valid) m_phase = (nib_data == m_xor) ? 2 : 3;
    end else if (reload) begin
      m_phase = 0;
      m_xor   = '0;
      m_words = 0;
      m_nibs.delete();
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Writes seen on the imem port, for the per-test literal checks.
  logic [AW-1:0] cap_addr[$];
  logic [WW-1:0] cap_data[$];

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("wr_en", 32'(wr_en), 32'(m_wr_en));
        if (m_wr_en) begin
          chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
          chk("wr_data", 32'(wr_data), 32'(m_wr_data));
        end
        chk("nib_ready", 32'(nib_ready), 32'(m_phase < 2));
        chk("busy", 32'(busy), 32'(m_phase < 2));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("err", 32'(err), 32'(m_phase == 3));
`ifndef LOADER_CHECKSUM_EN
        if (wr_en && wr_addr == AW'(DEPTH - 1)) chk("final_write_busy_done", 32'({busy, done}), 32'h1);
`endif
        if (wr_en) begin
          cap_addr.push_back(wr_addr);
          cap_data.push_back(wr_data);
        end
      end
    end
  end

  task automatic send_nib(input logic [3:0] n, input int gap);
    nib_valid = 1'b1;
    nib_data  = n;
    @(negedge clk);
    nib_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Words base+0 .. base+7, LSB nibble first, plus the correct checksum when enabled.
  task automatic send_stream(input logic [15:0] base, input int gap);
    logic [15:0] w;
`ifdef LOADER_CHECKSUM_EN
    logic [3:0] x;
    x = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      w = base + 16'(i);
      for (int k = 0; k < 4; k++) begin
        send_nib(w[4*k +: 4], gap);
`ifdef LOADER_CHECKSUM_EN
        x = x ^ w[4*k +: 4];
`endif
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_nib(x, gap);
`endif
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic check_caps(input string tag, input logic [15:0] base);
    chk({tag, "_count"}, 32'(cap_addr.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < cap_addr.size(); i++) begin
      chk({tag, "_addr"}, 32'(cap_addr[i]), 32'(i));
      chk({tag, "_data"}, 32'(cap_data[i]), 32'(base + 16'(i)));
    end
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    nib_valid = 1'b0;
    nib_data  = '0;
    reload    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_ready", 32'(nib_ready), 32'h1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 1: continuous stream
    clear_caps();
    send_stream(16'h1000, 0);
    repeat (3) @(negedge clk);
    check_caps("t1", 16'h1000);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_busy", 32'(busy), 32'h0);

    // 2: three idle cycles between nibbles
    do_reload();
    clear_caps();
    send_stream(16'h1000, 3);
    repeat (3) @(negedge clk);
    check_caps("t2", 16'h1000);
    chk("t2_done", 32'(done), 32'h1);

    // 3: reset after six nibbles discards the partial word
    do_reload();
    for (int i = 0; i < 6; i++) begin
      logic [15:0] w;
      w = 16'h1000 + 16'(i / 4);
      send_nib(w[4*(i%4) +: 4], 0);
    end
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("t3_rst_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    clear_caps();
    send_stream(16'h3000, 0);
    repeat (3) @(negedge clk);
    check_caps("t3", 16'h3000);

    // 4: nibble offered with reload is dropped, then a fresh load
    clear_caps();
    reload    = 1'b1;
    nib_valid = 1'b1;
    nib_data  = 4'hF;
    chk("t4_ready_in_reload", 32'(nib_ready), 32'h0);
    @(negedge clk);
    reload    = 1'b0;
    nib_valid = 1'b0;
    chk("t4_busy", 32'(busy), 32'h1);
    chk("t4_done", 32'(done), 32'h0);
    send_stream(16'h2000, 0);
    repeat (3) @(negedge clk);
    check_caps("t4", 16'h2000);

    // 5: nibbles offered after done are ignored
    clear_caps();
    for (int i = 0; i < 8; i++) send_nib(4'(i), 0);
    repeat (2) @(negedge clk);
    chk("t5_writes", 32'(cap_addr.size()), 32'h0);
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_ready", 32'(nib_ready), 32'h0);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum pass, then fail
    do_reload();
    for (int i = 0; i < 4 * DEPTH; i++) send_nib(4'hA, 0);
    send_nib(4'h0, 0);
    repeat (2) @(negedge clk);
    chk("t6_pass_done", 32'(done), 32'h1);
    chk("t6_pass_err", 32'(err), 32'h0);
    do_reload();
    for (int i = 0; i < 4 * DEPTH; i++) send_nib(4'hA, 0);
    send_nib(4'h3, 0);
    repeat (2) @(negedge clk);
    chk("t6_fail_err", 32'(err), 32'h1);
    chk("t6_fail_done", 32'(done), 32'h0);
    chk("t6_fail_ready", 32'(nib_ready), 32'h0);
    clear_caps();
    send_nib(4'h5, 0);
    repeat (2) @(negedge clk);
    chk("t6_fail_nowrite", 32'(cap_addr.size()), 32'h0);
    chk("t6_fail_hold", 32'(err), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
